chs_actuator_driver: RTL and testbench

Downstream stage of the cool/heat controller. It consumes the controller's power level, mode and PWM stream and drives the physical heater and cooler enables plus a slew-limited drive level. It guarantees the heater and cooler are never enabled together, and that a drain-to-zero plus dead time separates every heat/cool changeover. It also measures PWM duty per window and latches a fault if the PWM stream stops toggling while a mid-range power level is requested.

---
 rtl/chs_actuator_driver.sv | 154 +++++++++++++++
 tb/tb_chs_actuator_driver.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/chs_actuator_driver.sv
// Heater/cooler actuator driver: interlocked enables, slew-limited level, PWM duty and stuck-stream fault.
// Latency: every output is registered, so an input change shows up one clock later; the level moves one step per window.
// Backpressure: none; the driver follows its inputs every clock and never stalls the controller.
module chs_actuator_driver #(
    parameter int WIN_LOG2      = 6,
    parameter int DEAD_CYCLES   = 16,
    parameter int STUCK_WINDOWS = 4
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [3:0]          chs_power,
    input  logic                chs_mode,
    input  logic                pwm_data,
    output logic                heat_en,
    output logic                cool_en,
    output logic [3:0]          drive_level,
    output logic [WIN_LOG2:0]   duty_meas,
    output logic                pwm_fault
);

    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int SW = $clog2(STUCK_WINDOWS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DEAD} state_t;

    logic [WIN_LOG2-1:0] win_cnt;
    logic [WIN_LOG2:0]   hi_cnt;
    logic [WIN_LOG2:0]   hi_nxt;
    logic                prev_pwm;
    logic                edge_seen;
    logic                win_edge;
    logic                tick;
    logic                mid_power;
    logic [SW-1:0]       stuck_cnt;
    logic [SW-1:0]       stuck_nxt;
    logic [3:0]          target;

    state_t              state, state_nxt;
    logic                active_mode, mode_nxt;
    logic [3:0]          level_nxt;
    logic [DW-1:0]       dead_cnt, dead_nxt;
    logic                en_nxt;

    assign tick      = &win_cnt;
    assign hi_nxt    = hi_cnt + {{WIN_LOG2{1'b0}}, pwm_data};
    assign win_edge  = edge_seen | (pwm_data ^ prev_pwm);
    assign mid_power = (chs_power != 4'd0) && (chs_power != 4'd15);
    assign target    = pwm_fault ? 4'd0 : chs_power;

    // A window only counts as stuck when the controller should be modulating.
    always_comb begin
        stuck_nxt = stuck_cnt;
        if (tick) begin
            if (!win_edge && mid_power) begin
                if (stuck_cnt != SW'(STUCK_WINDOWS))
                    stuck_nxt = stuck_cnt + SW'(1);
            end else begin
                stuck_nxt = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            win_cnt   <= '0;
            hi_cnt    <= '0;
            duty_meas <= '0;
            prev_pwm  <= 1'b0;
            edge_seen <= 1'b0;
            stuck_cnt <= '0;
            pwm_fault <= 1'b0;
        end else begin
            win_cnt   <= win_cnt + WIN_LOG2'(1);
            prev_pwm  <= pwm_data;
            stuck_cnt <= stuck_nxt;
            if (stuck_nxt == SW'(STUCK_WINDOWS))
                pwm_fault <= 1'b1;
            if (tick) begin
                duty_meas <= hi_nxt;
                hi_cnt    <= '0;
                edge_seen <= 1'b0;
            end else begin
                hi_cnt    <= hi_nxt;
                edge_seen <= win_edge;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = active_mode;
        level_nxt = drive_level;
        dead_nxt  = dead_cnt;
        case (state)
            IDLE: begin
                level_nxt = 4'd0;
                if (target != 4'd0) begin
                    mode_nxt  = chs_mode;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (chs_mode != active_mode || target == 4'd0) begin
                    state_nxt = DRAIN;
                end else if (tick) begin
                    if (drive_level < target)
                        level_nxt = drive_level + 4'd1;
                    else if (drive_level > target)
                        level_nxt = drive_level - 4'd1;
                end
            end
            DRAIN: begin
                // Reaching zero wins over a late return request so the changeover always completes.
                if (drive_level == 4'd0) begin
                    state_nxt = DEAD;
                    dead_nxt  = '0;
                end else if (chs_mode == active_mode && target != 4'd0) begin
                    state_nxt = RUN;
                end else if (tick) begin
                    level_nxt = drive_level - 4'd1;
                end
            end
            DEAD: begin
                if (dead_cnt == DW'(DEAD_CYCLES))
                    state_nxt = IDLE;
                else
                    dead_nxt = dead_cnt + DW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enables are derived from the next state and mode, so at most one can ever be set.
    assign en_nxt = (state_nxt == RUN) || (state_nxt == DRAIN);

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state       <= IDLE;
            active_mode <= 1'b0;
            drive_level <= 4'd0;
            dead_cnt    <= '0;
            heat_en     <= 1'b0;
            cool_en     <= 1'b0;
        end else begin
            state       <= state_nxt;
            active_mode <= mode_nxt;
            drive_level <= level_nxt;
            dead_cnt    <= dead_nxt;
            heat_en     <= en_nxt & mode_nxt;
            cool_en     <= en_nxt & ~mode_nxt;
        end
    end

endmodule

// File: tb/tb_chs_actuator_driver.sv
// Bench for chs_actuator_driver: directed stimulus with scoreboard queues for output-state changes and per-window duty.
// Latency: expected changes carry a cycle gap, either from the previous change or from the stimulus mark.
// Backpressure: not applicable; monitors sample on the falling edge.
module tb_chs_actuator_driver;

    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic [3:0] chs_power = 4'd0;
    logic       chs_mode = 1'b0;
    logic       pwm_data = 1'b0;
    logic       heat_en, cool_en, pwm_fault;
    logic [3:0] drive_level;
    logic [6:0] duty_meas;

    chs_actuator_driver #(.WIN_LOG2(6), .DEAD_CYCLES(16), .STUCK_WINDOWS(4)) dut (
        .clk(clk), .arst(arst), .chs_power(chs_power), .chs_mode(chs_mode),
        .pwm_data(pwm_data), .heat_en(heat_en), .cool_en(cool_en),
        .drive_level(drive_level), .duty_meas(duty_meas), .pwm_fault(pwm_fault)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [6:0] tup;
        int         gap;
        bit         rel;
    } exp_t;

    exp_t       sq[$];
    int         dq[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_overlap = 0;
    int         cyc = 0;
    int         mark = 0;
    logic [5:0] wc = 6'd0;
    int         mode_req = 2;
    int         mode_cur = 2;
    int         hc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    endtask

    task automatic expect_st(input bit h, input bit c, input int lvl, input bit f, input int gap, input bit rel);
        exp_t e;
        e.tup = {h, c, 4'(lvl), f};
        e.gap = gap;
        e.rel = rel;
        sq.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Window phase of the upcoming sample, so pwm modes switch only on window boundaries.
    initial forever begin
        @(posedge clk or negedge arst);
        if (!arst) wc = 6'd0;
        else       wc = wc + 6'd1;
    end

    // PWM source: also predicts each window's duty and queues it.
    initial forever begin
        @(negedge clk);
        if (wc == 6'd0) begin
            mode_cur = mode_req;
            hc = 0;
        end
        case (mode_cur)
            0:       pwm_data = 1'b0;
            1:       pwm_data = 1'b1;
            default: pwm_data = (wc < 6'd48);
        endcase
        hc = hc + int'(pwm_data);
        if (arst && wc == 6'd63) dq.push_back(hc);
    end

    initial forever begin
        int e;
        @(negedge clk);
        if (arst && wc == 6'd0 && dq.size() > 0) begin
            e = dq.pop_front();
            check("duty_meas", int'(duty_meas), e);
        end
    end

    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        int         last;
        exp_t       e;
        prev = 7'd0;
        last = 0;
        forever begin
            @(negedge clk);
            if (heat_en & cool_en) n_overlap++;
            cur = {heat_en, cool_en, drive_level, pwm_fault};
            if (cur != prev) begin
                if (sq.size() == 0) begin
                    check("unexpected_state_change", int'(cur), int'(prev));
                end else begin
                    e = sq.pop_front();
                    check("state{heat,cool,level,fault}", int'(cur), int'(e.tup));
                    if (e.gap >= 0)
                        check(e.rel ? "gap_from_stimulus" : "gap_from_prev_change",
                              cyc - (e.rel ? mark : last), e.gap);
                end
                last = cyc;
                prev = cur;
            end
        end
    end

    task automatic wait_win(input int n);
        repeat (n * 64) @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input logic [5:0] k);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (wc != k && n < 200);
        check("phase_wait_bound", int'(n < 200), 1);
    endtask

    task automatic drive(input int p, input bit m);
        chs_power = 4'(p);
        chs_mode  = m;
        mark      = cyc;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_heat_en"}, int'(heat_en), 0);
        check({tag, "_cool_en"}, int'(cool_en), 0);
        check({tag, "_drive_level"}, int'(drive_level), 0);
        check({tag, "_duty_meas"}, int'(duty_meas), 0);
        check({tag, "_pwm_fault"}, int'(pwm_fault), 0);
    endtask

    // Reset is asserted between edges and checked before the next edge arrives.
    task automatic do_reset(input int p, input bit m, input int mr);
        @(posedge clk);
        #2;
        arst = 1'b0;
        dq.delete();
        #1;
        check_zero("async_reset");
        mode_req  = mr;
        chs_power = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b1;
        drive(p, m);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        arst = 1'b1;

        // Duty: 48-of-64 pattern, then constant high at zero power.
        wait_win(3);
        mode_req = 1;
        wait_win(3);
        mode_req = 2;
        wait_win(2);

        // Ramp up to 5 in heat.
        expect_st(1, 0, 0, 0, 1, 1);
        expect_st(1, 0, 1, 0, -1, 0);
        for (int l = 2; l <= 5; l++) expect_st(1, 0, l, 0, 64, 0);
        drive(5, 1);
        wait_win(8);
        expect_st(1, 0, 6, 0, -1, 0);
        drive(6, 1);
        wait_win(2);

        // Abort drain: two ticks of cool request, then back to heat.
        expect_st(1, 0, 5, 0, -1, 0);
        expect_st(1, 0, 4, 0, 64, 0);
        expect_st(1, 0, 5, 0, 64, 0);
        expect_st(1, 0, 6, 0, 64, 0);
        wait_phase(6'd1);
        chs_mode = 1'b0;
        wait_phase(6'd1);
        wait_phase(6'd1);
        chs_mode = 1'b1;
        wait_win(4);

        // Changeover heat -> cool from level 5.
        expect_st(1, 0, 5, 0, -1, 0);
        drive(5, 1);
        wait_win(2);
        expect_st(1, 0, 4, 0, -1, 0);
        for (int l = 3; l >= 0; l--) expect_st(1, 0, l, 0, 64, 0);
        expect_st(0, 0, 0, 0, 1, 0);
        expect_st(0, 1, 0, 0, 18, 0);
        expect_st(0, 1, 1, 0, -1, 0);
        for (int l = 2; l <= 5; l++) expect_st(0, 1, l, 0, 64, 0);
        chs_mode = 1'b0;
        wait_win(14);

        // Stuck-low PWM at mid power trips the fault after four edge-free windows.
        expect_st(0, 1, 6, 0, -1, 0);
        expect_st(0, 1, 7, 0, 64, 0);
        expect_st(0, 1, 7, 1, 192, 0);
        for (int l = 6; l >= 0; l--) expect_st(0, 1, l, 1, 64, 0);
        expect_st(0, 0, 0, 1, 1, 0);
        wait_phase(6'd10);
        chs_power = 4'd7;
        mode_req  = 0;
        wait_win(15);
        mode_req = 2;
        wait_win(3);

        // Reset clears the fault; after release the FSM starts from IDLE with the window counter at 0.
        expect_st(0, 0, 0, 0, -1, 0);
        expect_st(1, 0, 0, 0, 1, 1);
        expect_st(1, 0, 1, 0, 64, 1);
        for (int l = 2; l <= 5; l++) expect_st(1, 0, l, 0, 64, 0);
        do_reset(5, 1, 2);
        wait_win(7);

        // Reset mid-run at heat level 5, then full power with PWM stuck high: no fault.
        expect_st(0, 0, 0, 0, -1, 0);
        expect_st(1, 0, 0, 0, 1, 1);
        expect_st(1, 0, 1, 0, 64, 1);
        for (int l = 2; l <= 15; l++) expect_st(1, 0, l, 0, 64, 0);
        do_reset(15, 1, 1);
        wait_win(18);

        check("pending_expected_changes", sq.size(), 0);
        check("heat_cool_overlap_cycles", n_overlap, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
